// File: rtl/qsys_nios2_gen2_0_cpu_mult_combine.sv
// rtl/qsys_nios2_gen2_0_cpu_mult_combine.sv - sums 16x16 partial products into the 32-bit MUL result
// Optional macro MULT_COMBINE_HI_EN adds the iterative hi*hi engine for MULXUU.
module qsys_nios2_gen2_0_cpu_mult_combine #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_en,
  input  logic        M_valid_mul,
  input  logic        M_mul_hi_req,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic [15:0] M_src1_hi,
  input  logic [15:0] M_src2_hi,
  output logic [31:0] A_mul_result,
  output logic        A_mul_result_valid,
  output logic        A_mul_stall
);

  logic [32:0] mid;
  logic [32:0] low_sum;
  logic        capture;

  assign mid     = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
  assign low_sum = {1'b0, M_mul_cell_p1} + {1'b0, mid[15:0], 16'h0000};

`ifdef MULT_COMBINE_HI_EN
  localparam int         ITERS = 16 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST  = 5'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [15:0] mplier, mplier_nxt;
  logic [16:0] mid_hi, mid_hi_nxt;
  logic        carry, carry_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [31:0] result_nxt;
  logic [31:0] partial;
  logic        valid_nxt;
  logic        stall_nxt;

  assign capture = M_en & M_valid_mul & (state == IDLE);
  // Multiplicand is pre-shifted each iteration, so the digit product lands in place.
  assign partial = mcand * 32'(mplier[BITS_PER_CYCLE-1:0]);

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    mid_hi_nxt = mid_hi;
    carry_nxt  = carry;
    cnt_nxt    = cnt;
    result_nxt = A_mul_result;
    valid_nxt  = 1'b0;
    stall_nxt  = A_mul_stall;
    case (state)
      IDLE: begin
        if (capture) begin
          if (M_mul_hi_req) begin
            state_nxt  = ITER;
            acc_nxt    = 32'h0;
            mcand_nxt  = {16'h0000, M_src1_hi};
            mplier_nxt = M_src2_hi;
            mid_hi_nxt = mid[32:16];
            carry_nxt  = low_sum[32];
            cnt_nxt    = 5'd0;
            stall_nxt  = 1'b1;
          end else begin
            result_nxt = low_sum[31:0];
            valid_nxt  = 1'b1;
          end
        end
      end
      ITER: begin
        acc_nxt    = acc + partial;
        mcand_nxt  = mcand << BITS_PER_CYCLE;
        mplier_nxt = mplier >> BITS_PER_CYCLE;
        cnt_nxt    = cnt + 5'd1;
        if (cnt == LAST) state_nxt = FINAL;
      end
      FINAL: begin
        result_nxt = acc + {15'h0000, mid_hi} + {31'h0, carry};
        valid_nxt  = 1'b1;
        stall_nxt  = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      acc                <= 32'h0;
      mcand              <= 32'h0;
      mplier             <= 16'h0;
      mid_hi             <= 17'h0;
      carry              <= 1'b0;
      cnt                <= 5'd0;
      A_mul_result       <= 32'h0;
      A_mul_result_valid <= 1'b0;
      A_mul_stall        <= 1'b0;
    end else begin
      state              <= state_nxt;
      acc                <= acc_nxt;
      mcand              <= mcand_nxt;
      mplier             <= mplier_nxt;
      mid_hi             <= mid_hi_nxt;
      carry              <= carry_nxt;
      cnt                <= cnt_nxt;
      A_mul_result       <= result_nxt;
      A_mul_result_valid <= valid_nxt;
      A_mul_stall        <= stall_nxt;
    end
  end
`else
  logic unused_hi;

  assign unused_hi   = ^{M_mul_hi_req, M_src1_hi, M_src2_hi, mid[32:16], low_sum[32]};
  assign capture     = M_en & M_valid_mul;
  assign A_mul_stall = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A_mul_result       <= 32'h0;
      A_mul_result_valid <= 1'b0;
    end else begin
      if (capture) A_mul_result <= low_sum[31:0];
      A_mul_result_valid <= capture;
    end
  end
`endif

endmodule

// File: tb/tb_qsys_nios2_gen2_0_cpu_mult_combine.sv
// tb/tb_qsys_nios2_gen2_0_cpu_mult_combine.sv - bench for the multiply combine stage
// Instances with BITS_PER_CYCLE 1 and 4, a 64-bit product model and directed vectors.
module tb_qsys_nios2_gen2_0_cpu_mult_combine;

`ifdef MULT_COMBINE_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en1 = 1'b0, en4 = 1'b0, vmul = 1'b0, hi_req = 1'b0;
  logic [31:0] p1 = 32'h0, p2 = 32'h0, p3 = 32'h0;
  logic [15:0] s1 = 16'h0, s2 = 16'h0;
  logic [31:0] res1, res4;
  logic        val1, val4, stall1, stall4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qsys_nios2_gen2_0_cpu_mult_combine #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .M_en(en1), .M_valid_mul(vmul), .M_mul_hi_req(hi_req),
    .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
    .M_src1_hi(s1), .M_src2_hi(s2),
    .A_mul_result(res1), .A_mul_result_valid(val1), .A_mul_stall(stall1)
  );

  qsys_nios2_gen2_0_cpu_mult_combine #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .M_en(en4), .M_valid_mul(vmul), .M_mul_hi_req(hi_req),
    .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
    .M_src1_hi(s1), .M_src2_hi(s2),
    .A_mul_result(res4), .A_mul_result_valid(val4), .A_mul_stall(stall4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: full 64-bit product from the partials, a busy countdown per instance.
  logic [31:0] e_res[2];
  logic        e_val[2];
  logic        e_stall[2];
  int          e_cnt[2];
  logic [31:0] e_pend[2];

  always @(posedge clk or posedge reset) begin
    logic [63:0] full;
    logic        en_i;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        e_res[i] = 32'h0; e_val[i] = 1'b0; e_stall[i] = 1'b0; e_cnt[i] = 0; e_pend[i] = 32'h0;
      end else begin
        en_i = (i == 0) ? en1 : en4;
        e_val[i] = 1'b0;
        if (e_cnt[i] > 0) begin
          e_cnt[i]--;
          if (e_cnt[i] == 0) begin
            e_res[i] = e_pend[i]; e_val[i] = 1'b1; e_stall[i] = 1'b0;
          end
        end else if (en_i && vmul) begin
          full = {32'h0, p1} + ({32'h0, p2} << 16) + ({32'h0, p3} << 16) + ({48'h0, s1} * {48'h0, s2} << 32);
          if (hi_req && HI_EN) begin
            e_pend[i] = full[63:32];
            e_cnt[i]  = ((i == 0) ? 16 : 4) + 1;
            e_stall[i] = 1'b1;
          end else begin
            e_res[i] = full[31:0]; e_val[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("res1", res1, e_res[0]);
    chk("val1", {31'h0, val1}, {31'h0, e_val[0]});
    chk("stall1", {31'h0, stall1}, {31'h0, e_stall[0]});
    chk("res4", res4, e_res[1]);
    chk("val4", {31'h0, val4}, {31'h0, e_val[1]});
    chk("stall4", {31'h0, stall4}, {31'h0, e_stall[1]});
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [15:0] x, input logic [15:0] y, input logic h);
    p1 = a; p2 = b; p3 = c; s1 = x; s2 = y; hi_req = h; vmul = 1'b1;
  endtask

  // Called right after the capture edge's negedge; counts edges until valid.
  task automatic wait_valid(input int which, output int n);
    n = 0;
    while (((which == 0) ? val1 : val4) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_vec++; n_bad++;
      $display("FAIL timeout waiting for valid on instance %0d", which);
    end
  endtask

  int n;
  int pulses;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_res", res1, 32'h0);
    chk("reset_valid", {31'h0, val1}, 32'h0);
    chk("reset_stall", {31'h0, stall1}, 32'h0);

    // Low op
    drive(32'h0000000F, 32'h6, 32'h5, 16'h1, 16'h2, 1'b0); en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    chk("low_res", res1, 32'h000B000F);
    chk("low_valid", {31'h0, val1}, 32'h1);
    @(negedge clk);
    chk("low_pulse_end", {31'h0, val1}, 32'h0);
    chk("low_hold", res1, 32'h000B000F);

    // Carry wrap, low then hi
    drive(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 1'b0); en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    chk("wrap_low", res1, 32'h00000001);
    hi_req = 1'b1; en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    wait_valid(0, n);
    chk("wrap_hi", res1, HI_EN ? 32'hFFFFFFFE : 32'h00000001);
    chk("wrap_hi_lat", n, HI_EN ? 17 : 0);
    @(negedge clk);

    // Hi op, both engine widths
    drive(32'h0000000F, 32'h6, 32'h5, 16'h1, 16'h2, 1'b1); en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    wait_valid(0, n);
    chk("hi1_res", res1, HI_EN ? 32'h00000002 : 32'h000B000F);
    chk("hi1_lat", n, HI_EN ? 17 : 0);
    en4 = 1'b1;
    @(negedge clk); en4 = 1'b0;
    wait_valid(1, n);
    chk("hi4_res", res4, HI_EN ? 32'h00000002 : 32'h000B000F);
    chk("hi4_lat", n, HI_EN ? 5 : 0);
    @(negedge clk);

    // Protocol violation: M_en pulsed while busy
    drive(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 1'b1); en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    repeat (3) @(negedge clk);
    drive(32'h00000010, 32'h00010000, 32'h00000001, 16'h0, 16'h0, 1'b0); en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    wait_valid(0, n);
    chk("proto_res", res1, HI_EN ? 32'hFFFFFFFE : 32'h00010010);
    @(negedge clk);

    // Three back-to-back low captures
    drive(32'h0000000F, 32'h6, 32'h5, 16'h0, 16'h0, 1'b0); en1 = 1'b1;
    @(negedge clk);
    chk("b2b_0", res1, 32'h000B000F);
    drive(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    chk("b2b_1", res1, 32'h00000001);
    chk("b2b_1_valid", {31'h0, val1}, 32'h1);
    drive(32'h00000010, 32'h00010000, 32'h00000001, 16'h0, 16'h0, 1'b0);
    @(negedge clk); en1 = 1'b0;
    chk("b2b_2", res1, 32'h00010010);
    chk("b2b_2_valid", {31'h0, val1}, 32'h1);
    @(negedge clk);

    // Reset in the middle of a hi op
    drive(32'h0000000F, 32'h6, 32'h5, 16'h1, 16'h2, 1'b1); en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_stall", {31'h0, stall1}, 32'h0);
    chk("rst_res", res1, 32'h0);
    chk("rst_valid", {31'h0, val1}, 32'h0);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (val1 === 1'b1) pulses++;
    end
    chk("rst_no_pulse", pulses, 0);
    drive(32'h0000000F, 32'h6, 32'h5, 16'h1, 16'h2, 1'b0); en1 = 1'b1;
    @(negedge clk); en1 = 1'b0;
    chk("post_rst_low", res1, 32'h000B000F);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
